// File: rtl/buttfly_qor_pkg.sv
// Shared definitions for the buttfly quality-of-result monitors.
//   err_mon_state_t : monitor FSM state encoding
//   flip_cnt_w()    : width of a bit-flip accumulator for a given word width/window
//   err_rec_t       : one result record for the 8-bit buttfly_0 partition over a
//                     1024-sample window, for consumers that handle whole records
package buttfly_qor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } err_mon_state_t;

  // A word of w bits flips at most w bits, so the per-sample popcount needs
  // $clog2(w+1) bits. A window of 2**win_log2 samples adds win_log2 more bits.
  function automatic int flip_cnt_w(input int w, input int win_log2);
    return $clog2(w + 1) + win_log2;
  endfunction

  localparam int QOR_W        = 8;
  localparam int QOR_WIN_LOG2 = 10;

  typedef struct packed {
    logic [QOR_WIN_LOG2:0]                       err_cnt;
    logic [flip_cnt_w(QOR_W, QOR_WIN_LOG2)-1:0]  flip_cnt;
    logic [QOR_W+QOR_WIN_LOG2-1:0]               sum_abs;
    logic [QOR_W-1:0]                            max_abs;
  } err_rec_t;

endpackage

// File: rtl/buttfly_err_metric.sv
// Combinational per-sample error metrics for one approximate/exact word pair.
//   a, e      : approximate and exact words (unsigned, W bits)
//   mismatch  : 1 when any bit differs
//   pop       : number of differing bits
//   absd      : |a - e|
module buttfly_err_metric #(
  parameter int W = 8
) (
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           e,
  output logic                   mismatch,
  output logic [$clog2(W+1)-1:0] pop,
  output logic [W-1:0]           absd
);

  localparam int PW = $clog2(W + 1);

  // Both operands are unsigned, so a W+1-bit signed difference always holds
  // the exact result and its magnitude always fits back into W bits.
  function automatic logic [W-1:0] abs_diff(input logic signed [W:0] d);
    logic signed [W:0] m;
    m = (d < 0) ? -d : d;
    return m[W-1:0];
  endfunction

  logic [W-1:0]      x;
  logic signed [W:0] diff;

  always_comb begin
    x        = a ^ e;
    mismatch = |x;
    pop      = '0;
    for (int i = 0; i < W; i++) begin
      pop = pop + PW'(x[i]);
    end
    diff = $signed({1'b0, a}) - $signed({1'b0, e});
    absd = abs_diff(diff);
  end

endmodule

// File: rtl/buttfly_0_err_monitor.sv
// Error-statistics monitor for the approximate buttfly_0 partition.
// Compares each approximate word with its exact reference over a window of
// 2**WIN_LOG2 accepted samples and returns one result record per window.
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : open a window (IDLE only) / drop back to IDLE at any time
//   in_valid/in_ready : sample pair handshake for approx_w, exact_w
//   busy              : window collection or pipeline drain in progress
//   res_valid/ready   : result record handshake
//   res_err_cnt       : samples with approx_w != exact_w
//   res_flip_cnt      : total differing bits
//   res_sum_abs       : sum of |approx_w - exact_w|
//   res_max_abs       : largest |approx_w - exact_w|
module buttfly_0_err_monitor
  import buttfly_qor_pkg::*;
#(
  parameter int W        = 8,
  parameter int WIN_LOG2 = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [W-1:0]                        approx_w,
  input  logic [W-1:0]                        exact_w,
  output logic                                busy,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [WIN_LOG2:0]                   res_err_cnt,
  output logic [flip_cnt_w(W, WIN_LOG2)-1:0]  res_flip_cnt,
  output logic [W+WIN_LOG2-1:0]               res_sum_abs,
  output logic [W-1:0]                        res_max_abs
);

  localparam int PW = $clog2(W + 1);
  localparam int EW = WIN_LOG2 + 1;
  localparam int FW = flip_cnt_w(W, WIN_LOG2);
  localparam int SW = W + WIN_LOG2;
  localparam logic [WIN_LOG2:0] WIN_N    = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [WIN_LOG2:0] WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};

  err_mon_state_t state, state_nxt;
  logic [WIN_LOG2:0] cnt;
  logic              accept;
  logic              open_win;
  logic              vld_p1, vld_p2;

  logic              mis_p0;
  logic [PW-1:0]     pop_p0;
  logic [W-1:0]      absd_p0;
  logic              mis_p1, mis_p2;
  logic [PW-1:0]     pop_p1, pop_p2;
  logic [W-1:0]      absd_p1, absd_p2;

  logic [EW-1:0]     acc_err;
  logic [FW-1:0]     acc_flip;
  logic [SW-1:0]     acc_sum;
  logic [W-1:0]      acc_max;

  assign in_ready  = (state == ST_RUN) && (cnt < WIN_N);
  assign accept    = in_valid && in_ready;
  assign open_win  = (state == ST_IDLE) && start && !abort;
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign res_valid = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (accept && cnt == WIN_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!vld_p1 && !vld_p2) state_nxt = ST_DONE;
      ST_DONE:  if (res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else if (open_win) begin
        cnt    <= '0;
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        vld_p1 <= accept;
        vld_p2 <= vld_p1;
        if (accept) cnt <= cnt + 1'b1;
      end
    end
  end

  // ---- stage p0 -> p1: per-sample metrics of the accepted pair ----
  buttfly_err_metric #(.W(W)) u_metric (
    .a        (approx_w),
    .e        (exact_w),
    .mismatch (mis_p0),
    .pop      (pop_p0),
    .absd     (absd_p0)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      mis_p1  <= mis_p0;
      pop_p1  <= pop_p0;
      absd_p1 <= absd_p0;
    end
  end

  // ---- stage p1 -> p2: metrics handed to the accumulator stage ----
  always_ff @(posedge clk) begin
    mis_p2  <= mis_p1;
    pop_p2  <= pop_p1;
    absd_p2 <= absd_p1;
  end

  // ---- stage p2 -> accumulators ----
  always_ff @(posedge clk) begin
    if (rst || open_win) begin
      acc_err  <= '0;
      acc_flip <= '0;
      acc_sum  <= '0;
      acc_max  <= '0;
    end else if (vld_p2 && !abort) begin
      acc_err  <= acc_err + EW'(mis_p2);
      acc_flip <= acc_flip + FW'(pop_p2);
      acc_sum  <= acc_sum + SW'(absd_p2);
      acc_max  <= (absd_p2 > acc_max) ? absd_p2 : acc_max;
    end
  end

  // ---- accumulators -> result record, loaded once the pipeline is empty ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_err_cnt  <= '0;
      res_flip_cnt <= '0;
      res_sum_abs  <= '0;
      res_max_abs  <= '0;
    end else if (state == ST_DRAIN && state_nxt == ST_DONE) begin
      res_err_cnt  <= acc_err;
      res_flip_cnt <= acc_flip;
      res_sum_abs  <= acc_sum;
      res_max_abs  <= acc_max;
    end
  end

endmodule
